// File: rtl/rx_pkg.sv
// ==========================================================================
// rx_pkg: receive-chain shared types and constants. Rev 1.0
// ==========================================================================
`default_nettype none

package rx_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE    = 3'd0,
    SEQ_FLUSH   = 3'd1,
    SEQ_CAPTURE = 3'd2,
    SEQ_DRAIN   = 3'd3,
    SEQ_DONE    = 3'd4
  } discriminator_seq_state_t;

endpackage

`default_nettype wire

// File: rtl/tx_pkg.sv
// ==========================================================================
// tx_pkg: transmit-chain shared constants. Rev 1.0
// ==========================================================================
`default_nettype none

package tx_pkg;

  // Number of digital trigger lines into the discriminator.
  localparam int CHANNELS = 4;

endpackage

`default_nettype wire

// File: rtl/sample_discriminator_sequencer.sv
// ==========================================================================
// sample_discriminator_sequencer: flush / capture / drain sequencer for a
// sample_discriminator capture, all outputs registered. Rev 1.0
// ==========================================================================
`default_nettype none

module sample_discriminator_sequencer
  import rx_pkg::*;
#(
  parameter int MAX_DELAY_CYCLES = 128,
  parameter int COUNT_BITS       = 32,
  parameter int FLUSH_TIMEOUT    = 4 * MAX_DELAY_CYCLES
) (
  input  logic                        adc_clk,
  input  logic                        adc_reset,
  input  logic                        adc_start,
  input  logic                        adc_abort,
  input  logic [COUNT_BITS-1:0]       adc_capture_samples,
  input  logic [COUNT_BITS-1:0]       adc_trigger_offset,
  input  logic [tx_pkg::CHANNELS-1:0] adc_trigger_mask,
  input  logic                        adc_in_valid,
  input  logic                        adc_out_valid,
  output logic                        adc_reset_state,
  output logic [tx_pkg::CHANNELS-1:0] adc_digital_trigger_out,
  output logic                        adc_busy,
  output logic                        adc_done,
  output logic                        adc_timeout
);

  localparam int C_DRAIN_CYCLES = 2 + 2 * MAX_DELAY_CYCLES;
  localparam int C_DRAIN_W      = $clog2(C_DRAIN_CYCLES + 1);
  localparam int C_TO_W         = $clog2(FLUSH_TIMEOUT + 1);

  localparam logic [C_DRAIN_W-1:0] C_DRAIN_LAST = C_DRAIN_W'(C_DRAIN_CYCLES - 1);
  localparam logic [C_TO_W-1:0]    C_TO_LAST    = C_TO_W'(FLUSH_TIMEOUT - 1);

  discriminator_seq_state_t r_state;

  logic [COUNT_BITS-1:0]       r_cap;
  logic [COUNT_BITS-1:0]       r_off;
  logic [tx_pkg::CHANNELS-1:0] r_mask;
  logic                        r_trig_en;

  logic [COUNT_BITS-1:0]       r_sample_cnt;
  logic [C_DRAIN_W-1:0]        r_drain_cnt;
  logic [C_TO_W-1:0]           r_to_cnt;
  logic                        r_flush_b;

  logic                        r_reset_state;
  logic [tx_pkg::CHANNELS-1:0] r_trig;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_timeout;

  logic [COUNT_BITS-1:0]       w_sample_inc;

  // Saturating increment so an all-ones capture length still terminates.
  assign w_sample_inc = (r_sample_cnt == {COUNT_BITS{1'b1}}) ? r_sample_cnt
                                                             : r_sample_cnt + COUNT_BITS'(1);

  always_ff @(posedge adc_clk) begin
    if (adc_reset) begin
      r_state       <= SEQ_IDLE;
      r_cap         <= '0;
      r_off         <= '0;
      r_mask        <= '0;
      r_trig_en     <= 1'b0;
      r_sample_cnt  <= '0;
      r_drain_cnt   <= '0;
      r_to_cnt      <= '0;
      r_flush_b     <= 1'b0;
      r_reset_state <= 1'b0;
      r_trig        <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_trig <= '0;
      r_done <= 1'b0;
      if (adc_abort) begin
        r_state       <= SEQ_IDLE;
        r_reset_state <= 1'b0;
        r_busy        <= 1'b0;
      end else begin
        case (r_state)
          SEQ_IDLE: begin
            if (adc_start) begin
              r_cap         <= adc_capture_samples;
              r_off         <= adc_trigger_offset;
              r_mask        <= adc_trigger_mask;
              r_trig_en     <= (adc_trigger_offset < adc_capture_samples) && (|adc_trigger_mask);
              r_timeout     <= 1'b0;
              r_to_cnt      <= '0;
              r_flush_b     <= 1'b0;
              r_reset_state <= 1'b1;
              r_busy        <= 1'b1;
              r_state       <= SEQ_FLUSH;
            end
          end

          // Phase A: first input valid; phase B: output side quiet.
          SEQ_FLUSH: begin
            if (r_flush_b && !adc_out_valid) begin
              r_state       <= SEQ_CAPTURE;
              r_reset_state <= 1'b0;
              r_sample_cnt  <= '0;
            end else if (r_to_cnt == C_TO_LAST) begin
              r_timeout     <= 1'b1;
              r_state       <= SEQ_IDLE;
              r_reset_state <= 1'b0;
              r_busy        <= 1'b0;
            end else begin
              r_to_cnt <= r_to_cnt + C_TO_W'(1);
              if (adc_in_valid) begin
                r_flush_b <= 1'b1;
              end
            end
          end

          SEQ_CAPTURE: begin
            if (r_cap == '0) begin
              r_state     <= SEQ_DRAIN;
              r_drain_cnt <= '0;
            end else if (adc_in_valid) begin
              r_sample_cnt <= w_sample_inc;
              if (r_trig_en && (r_sample_cnt == r_off)) begin
                r_trig <= r_mask;
              end
              if (w_sample_inc == r_cap) begin
                r_state     <= SEQ_DRAIN;
                r_drain_cnt <= '0;
              end
            end
          end

          SEQ_DRAIN: begin
            if (r_drain_cnt == C_DRAIN_LAST) begin
              r_state <= SEQ_DONE;
            end else begin
              r_drain_cnt <= r_drain_cnt + C_DRAIN_W'(1);
            end
          end

          SEQ_DONE: begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= SEQ_IDLE;
          end

          default: begin
            r_state       <= SEQ_IDLE;
            r_reset_state <= 1'b0;
            r_busy        <= 1'b0;
          end
        endcase
      end
    end
  end

  assign adc_reset_state         = r_reset_state;
  assign adc_digital_trigger_out = r_trig;
  assign adc_busy                = r_busy;
  assign adc_done                = r_done;
  assign adc_timeout             = r_timeout;

endmodule

`default_nettype wire
